// File: rtl/latch_bank_sched.sv
// Round-robin write sequencer for a bank of level-sensitive latches.
// Every output is a register loaded from the next-state decode, so it lines up with the state it belongs to.
module latch_bank_sched #(
   parameter int NUM_REQ  = 3,
   parameter int DW       = 8,
   parameter int OPEN_CYC = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ*DW-1:0] req_data,
   input  logic                  clr_req,
   output logic [NUM_REQ-1:0]    gnt,
   output logic                  busy,
   output logic [DW-1:0]         lat_data,
   output logic [NUM_REQ-1:0]    lat_en,
   output logic                  lat_rst
);

   localparam int         PW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [3:0] OPEN_LOAD = (OPEN_CYC <= 0) ? 4'd1 : 4'(OPEN_CYC);

   typedef enum logic [2:0] {IDLE, CLEAR, SETUP, OPEN, HOLD} state_t;

   state_t             state, state_nxt;
   logic [PW-1:0]      ptr, ptr_nxt;
   logic [PW-1:0]      win, win_nxt;
   logic [PW-1:0]      arb_idx;
   logic               arb_found;
   logic [3:0]         cnt, cnt_nxt;
   logic [NUM_REQ-1:0] req_eff;
   logic [NUM_REQ-1:0] gnt_nxt, lat_en_nxt;
   logic               busy_nxt, lat_rst_nxt;
   logic [DW-1:0]      lat_data_nxt;

   function automatic logic [NUM_REQ-1:0] onehot(input logic [PW-1:0] idx);
      onehot      = '0;
      onehot[idx] = 1'b1;
   endfunction

   // The requester just granted in HOLD is still raising req this cycle; it must not win again.
   always_comb begin
      req_eff = req;
      if (state == HOLD)
         req_eff = req & ~onehot(win);
      arb_found = 1'b0;
      arb_idx   = '0;
      // Scan downwards so the candidate closest to ptr is the last one written.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req_eff[(int'(ptr) + k) % NUM_REQ]) begin
            arb_found = 1'b1;
            arb_idx   = PW'((int'(ptr) + k) % NUM_REQ);
         end
      end
   end

   // Register process: FSM state, datapath and all outputs.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         state    <= IDLE;
         ptr      <= '0;
         win      <= '0;
         cnt      <= '0;
         gnt      <= '0;
         busy     <= 1'b0;
         lat_en   <= '0;
         lat_data <= '0;
         lat_rst  <= 1'b1;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         win      <= win_nxt;
         cnt      <= cnt_nxt;
         gnt      <= gnt_nxt;
         busy     <= busy_nxt;
         lat_en   <= lat_en_nxt;
         lat_data <= lat_data_nxt;
         lat_rst  <= lat_rst_nxt;
      end
   end

   // Next-state decode; a clear always beats a write at a decision point.
   always_comb begin
      // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
      state_nxt = state;
      unique case (state)
         IDLE, HOLD: begin
            if (clr_req)
               state_nxt = CLEAR;
            else if (arb_found)
               state_nxt = SETUP;
            else
               state_nxt = IDLE;
         end
         CLEAR: state_nxt = IDLE;
         SETUP: state_nxt = OPEN;
         OPEN:  if (cnt <= 4'd1) state_nxt = HOLD;
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode keyed on the state being entered, so registered outputs match the state.
   always_comb begin
      gnt_nxt      = '0;
      lat_en_nxt   = '0;
      lat_rst_nxt  = (state_nxt == CLEAR);
      busy_nxt     = (state_nxt != IDLE);
      lat_data_nxt = lat_data;
      win_nxt      = win;
      ptr_nxt      = ptr;
      cnt_nxt      = cnt;
      unique case (state_nxt)
         SETUP: begin
            // Data is loaded one cycle ahead of the enable so it is settled when the latch opens.
            win_nxt      = arb_idx;
            ptr_nxt      = (arb_idx == PW'(NUM_REQ - 1)) ? '0 : arb_idx + PW'(1);
            lat_data_nxt = req_data[int'(arb_idx) * DW +: DW];
            cnt_nxt      = OPEN_LOAD;
         end
         OPEN: begin
            lat_en_nxt = onehot(win);
            if (state == OPEN)
               cnt_nxt = cnt - 4'd1;
         end
         HOLD: gnt_nxt = onehot(win);
         default: ;
      endcase
   end

endmodule

// File: tb/tb_latch_bank_sched.sv
// Bench for latch_bank_sched: vector table, directed corner sequences and random traffic
// checked against a schedule-based reference model; invariants are checked every cycle.
module tb_latch_bank_sched;

   localparam int N  = 3;
   localparam int DW = 8;
   localparam int OC = 2;

   typedef struct packed {
      logic [N-1:0]  gnt;
      logic          busy;
      logic [DW-1:0] data;
      logic [N-1:0]  en;
      logic          rst;
   } out_t;

   typedef struct {
      logic [N-1:0]    req;
      logic            clr;
      logic [N*DW-1:0] rdata;
      out_t            exp;
   } vec_t;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [N-1:0]    req = '0;
   logic [N*DW-1:0] req_data = '0;
   logic            clr_req = 1'b0;
   logic [N-1:0]    gnt;
   logic            busy;
   logic [DW-1:0]   lat_data;
   logic [N-1:0]    lat_en;
   logic            lat_rst;

   int total = 0;
   int bad   = 0;

   out_t          sched[$];
   out_t          m_last;
   int            m_ptr = 0;
   logic          model_on = 1'b0;
   logic [DW-1:0] prev_data = '0;
   int            g_order[$];
   int            g_cyc[$];
   vec_t          vecs[12];

   latch_bank_sched #(.NUM_REQ(N), .DW(DW), .OPEN_CYC(OC)) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .req_data (req_data),
      .clr_req  (clr_req),
      .gnt      (gnt),
      .busy     (busy),
      .lat_data (lat_data),
      .lat_en   (lat_en),
      .lat_rst  (lat_rst)
   );

   always #5 clk = ~clk;

   function automatic out_t mk_out(input logic [N-1:0] g, input logic b, input logic [DW-1:0] d,
                                   input logic [N-1:0] e, input logic r);
      mk_out.gnt  = g;
      mk_out.busy = b;
      mk_out.data = d;
      mk_out.en   = e;
      mk_out.rst  = r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_out(input string tag, input out_t e);
      check({tag, "_gnt"},  32'(gnt),      32'(e.gnt));
      check({tag, "_busy"}, 32'(busy),     32'(e.busy));
      check({tag, "_data"}, 32'(lat_data), 32'(e.data));
      check({tag, "_en"},   32'(lat_en),   32'(e.en));
      check({tag, "_rst"},  32'(lat_rst),  32'(e.rst));
   endtask

   // Reference model: at each decision point a whole transaction is laid out as a
   // queue of per-cycle expected outputs; between decisions the queue is just replayed.
   task automatic model_update();
      out_t          nx;
      logic [N-1:0]  r;
      logic [N-1:0]  oh;
      logic [DW-1:0] d;
      int            w;
      int            open_n;
      if (reset) begin
         sched.delete();
         m_ptr = 0;
         nx = mk_out('0, 1'b0, '0, '0, 1'b1);
      end else begin
         if (sched.size() == 0 && !(m_last.rst && m_last.busy)) begin
            r = req & ~m_last.gnt;
            if (clr_req) begin
               sched.push_back(mk_out('0, 1'b1, m_last.data, '0, 1'b1));
            end else if (r != '0) begin
               w = -1;
               for (int k = 0; k < N; k++)
                  if (w < 0 && r[(m_ptr + k) % N]) w = (m_ptr + k) % N;
               m_ptr  = (w + 1) % N;
               d      = req_data[w*DW +: DW];
               oh     = '0;
               oh[w]  = 1'b1;
               open_n = (OC < 1) ? 1 : OC;
               sched.push_back(mk_out('0, 1'b1, d, '0, 1'b0));
               for (int k = 0; k < open_n; k++) sched.push_back(mk_out('0, 1'b1, d, oh, 1'b0));
               sched.push_back(mk_out(oh, 1'b1, d, '0, 1'b0));
            end
         end
         if (sched.size() != 0) nx = sched.pop_front();
         else                   nx = mk_out('0, 1'b0, m_last.data, '0, 1'b0);
      end
      m_last = nx;
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      check("inv_onehot", 32'($onehot0(lat_en)), 32'(1));
      check("inv_en_rst", 32'(!(lat_rst && |lat_en)), 32'(1));
      if (|lat_en) check("inv_data_stable", 32'(lat_data), 32'(prev_data));
      prev_data = lat_data;
      if (model_on) check_out("model", m_last);
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      req      = '0;
      clr_req  = 1'b0;
      req_data = '0;
      step();
      check_out("reset", mk_out('0, 1'b0, '0, '0, 1'b1));
      reset = 1'b0;
      step();
      check_out("post_reset", mk_out('0, 1'b0, '0, '0, 1'b0));
   endtask

   // Runs until n grants are seen or the budget expires; requesters drop req on their gnt.
   task automatic collect(input string tag, input int n, input int budget);
      g_order.delete();
      g_cyc.delete();
      for (int c = 0; c < budget && g_order.size() < n; c++) begin
         step();
         if (g_order.size() > 0) check({tag, "_busy"}, 32'(busy), 32'(1));
         if (|gnt) begin
            for (int i = 0; i < N; i++) if (gnt[i]) g_order.push_back(i);
            g_cyc.push_back(c);
            req = req & ~gnt;
         end
      end
      check({tag, "_count"}, 32'(g_order.size()), 32'(n));
   endtask

   initial begin
      int exp_b[2];
      m_last = mk_out('0, 1'b0, '0, '0, 1'b1);

      vecs[0]  = '{3'b010, 1'b0, 24'h00A500, mk_out(3'b000, 1'b1, 8'hA5, 3'b000, 1'b0)};
      vecs[1]  = '{3'b010, 1'b0, 24'h00A500, mk_out(3'b000, 1'b1, 8'hA5, 3'b010, 1'b0)};
      vecs[2]  = '{3'b010, 1'b0, 24'h00A500, mk_out(3'b000, 1'b1, 8'hA5, 3'b010, 1'b0)};
      vecs[3]  = '{3'b010, 1'b0, 24'h00A500, mk_out(3'b010, 1'b1, 8'hA5, 3'b000, 1'b0)};
      vecs[4]  = '{3'b000, 1'b0, 24'h000000, mk_out(3'b000, 1'b0, 8'hA5, 3'b000, 1'b0)};
      vecs[5]  = '{3'b001, 1'b1, 24'h00005A, mk_out(3'b000, 1'b1, 8'hA5, 3'b000, 1'b1)};
      vecs[6]  = '{3'b001, 1'b0, 24'h00005A, mk_out(3'b000, 1'b0, 8'hA5, 3'b000, 1'b0)};
      vecs[7]  = '{3'b001, 1'b0, 24'h00005A, mk_out(3'b000, 1'b1, 8'h5A, 3'b000, 1'b0)};
      vecs[8]  = '{3'b001, 1'b0, 24'h00005A, mk_out(3'b000, 1'b1, 8'h5A, 3'b001, 1'b0)};
      vecs[9]  = '{3'b001, 1'b0, 24'h00005A, mk_out(3'b000, 1'b1, 8'h5A, 3'b001, 1'b0)};
      vecs[10] = '{3'b001, 1'b0, 24'h00005A, mk_out(3'b001, 1'b1, 8'h5A, 3'b000, 1'b0)};
      vecs[11] = '{3'b000, 1'b0, 24'h000000, mk_out(3'b000, 1'b0, 8'h5A, 3'b000, 1'b0)};

      // Single write followed by clear-beats-write, one row per clock.
      do_reset();
      for (int i = 0; i < 12; i++) begin
         req      = vecs[i].req;
         clr_req  = vecs[i].clr;
         req_data = vecs[i].rdata;
         step();
         check_out($sformatf("vec%0d", i), vecs[i].exp);
      end

      // Round-robin: all three held, then 0 alone (ptr->1), then 0 and 2.
      do_reset();
      req      = 3'b111;
      req_data = 24'h332211;
      collect("rr_all", 3, 30);
      for (int k = 0; k < g_order.size(); k++)
         check($sformatf("rr_all_order%0d", k), 32'(g_order[k]), 32'(k));
      for (int k = 1; k < g_cyc.size(); k++)
         check($sformatf("rr_all_gap%0d", k), 32'(g_cyc[k] - g_cyc[k-1]), 32'(2 + OC));
      req = 3'b001;
      collect("rr_one", 1, 20);
      req = 3'b101;
      collect("rr_two", 2, 30);
      exp_b = '{2, 0};
      for (int k = 0; k < g_order.size(); k++)
         check($sformatf("rr_two_order%0d", k), 32'(g_order[k]), 32'(exp_b[k]));

      // Clear raised during OPEN waits until the write completes.
      do_reset();
      req      = 3'b001;
      req_data = 24'h000077;
      step();
      step();
      clr_req = 1'b1;
      step();
      check_out("clr_open2", mk_out(3'b000, 1'b1, 8'h77, 3'b001, 1'b0));
      step();
      check_out("clr_hold", mk_out(3'b001, 1'b1, 8'h77, 3'b000, 1'b0));
      req = '0;
      step();
      check_out("clr_clear", mk_out(3'b000, 1'b1, 8'h77, 3'b000, 1'b1));
      clr_req = 1'b0;
      step();
      check_out("clr_idle", mk_out(3'b000, 1'b0, 8'h77, 3'b000, 1'b0));

      // Request and data withdrawn mid-OPEN: the captured write still completes.
      do_reset();
      req      = 3'b100;
      req_data = 24'h3C0000;
      step();
      check_out("wd_setup", mk_out(3'b000, 1'b1, 8'h3C, 3'b000, 1'b0));
      step();
      check_out("wd_open1", mk_out(3'b000, 1'b1, 8'h3C, 3'b100, 1'b0));
      req      = '0;
      req_data = '0;
      step();
      check_out("wd_open2", mk_out(3'b000, 1'b1, 8'h3C, 3'b100, 1'b0));
      step();
      check_out("wd_hold", mk_out(3'b100, 1'b1, 8'h3C, 3'b000, 1'b0));

      // Reset mid-OPEN aborts the write and returns ptr to 0.
      do_reset();
      req      = 3'b010;
      req_data = 24'h002211;
      step();
      step();
      reset = 1'b1;
      step();
      check_out("rst_mid", mk_out(3'b000, 1'b0, 8'h00, 3'b000, 1'b1));
      reset = 1'b0;
      req   = 3'b011;
      collect("rst_rr", 2, 30);
      for (int k = 0; k < g_order.size(); k++)
         check($sformatf("rst_rr_order%0d", k), 32'(g_order[k]), 32'(k));

      // Random traffic against the reference model.
      do_reset();
      model_on = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         step();
         req = req & ~gnt;
         for (int i = 0; i < N; i++) begin
            if (!req[i] && $urandom_range(3) == 0) begin
               req[i] = 1'b1;
               req_data[i*DW +: DW] = 8'($urandom);
            end else if (req[i] && $urandom_range(7) == 0) begin
               req_data[i*DW +: DW] = 8'($urandom);
            end
         end
         clr_req = ($urandom_range(15) == 0);
         reset   = ($urandom_range(199) == 0);
      end
      model_on = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/latch_bank_sched.md
Name: latch_bank_sched

Overview:
- Sequencer and arbiter for a shared bank of NUM_REQ level-sensitive latches. Each latch has its own enable and a common async-style clear.
- Accepts write requests from NUM_REQ requesters and arbitrates them round-robin.
- Drives each accepted write with a glitch-free setup/open/hold enable sequence, so latch data is always stable around the enable pulse.
- Also sequences bank-wide clears.
- Sits between requester logic and the latch bank. It is the only driver of the latch enables and the latch reset.

Parameters:
- NUM_REQ, 3, number of requesters and latches (2..8).
- DW, 8, data width per latch write.
- OPEN_CYC, 2, cycles the latch enable is held high (1..15; 0 behaves as 1).

Ports:
- clk  in  1  single clock; all logic is posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester write request, level. Held until the matching gnt.
- req_data  in  NUM_REQ*DW  write data; requester i uses bits [i*DW +: DW].
- clr_req  in  1  bank clear request, level. Has priority over writes.
- gnt  out  NUM_REQ  one-cycle completion pulse, one-hot.
- busy  out  1  high whenever the state is not IDLE.
- lat_data  out  DW  registered data to the latch bank D inputs.
- lat_en  out  NUM_REQ  registered one-hot latch enable.
- lat_rst  out  1  registered latch bank clear.

Behaviour:
- All outputs are registered. There are no combinational paths from inputs to outputs.

Reset values:
- state = IDLE, gnt = 0, busy = 0, lat_en = 0, lat_data = 0, rr pointer = 0.
- lat_rst = 1 while reset is sampled high, so the bank clears during reset.
- lat_rst = 0 from the first edge after reset is sampled low, unless a CLEAR follows.

State machine (states IDLE, CLEAR, SETUP, OPEN, HOLD):
- IDLE:
  - clr_req=1 -> CLEAR.
  - Otherwise any req bit set -> choose winner w (round-robin) -> SETUP.
  - Otherwise stay in IDLE.
- CLEAR:
  - lat_rst=1 for exactly 1 cycle, lat_en=0, then -> IDLE.
  - A clr_req still high in IDLE re-triggers CLEAR (level semantics).
- SETUP:
  - lat_data <= req_data[w]; this capture happens exactly once per transaction. lat_en=0.
  - -> OPEN after 1 cycle.
- OPEN:
  - lat_en[w]=1 for exactly OPEN_CYC cycles, counted by a 4-bit down-counter.
  - lat_data is unchanged. Then -> HOLD.
- HOLD:
  - lat_en=0, lat_data unchanged, gnt[w]=1 for this single cycle.
  - Arbitration is evaluated in HOLD exactly as in IDLE. Priority is clr_req -> CLEAR, then req -> SETUP with a new winner, else -> IDLE.
  - For the arbitration done in HOLD, req[w] is masked out, because the requester drops it on gnt.

Timing:
- Latency from req sampled in IDLE to gnt is 2+OPEN_CYC cycles (SETUP, OPEN×OPEN_CYC, HOLD).
- Back-to-back throughput is one write per 2+OPEN_CYC cycles.

Arbitration:
- Round-robin. Search starts at index ptr and wraps modulo NUM_REQ.
- On a grant, ptr <= (w+1) mod NUM_REQ. ptr is unchanged by CLEAR.

Boundary conditions:
- lat_en is never high in the same cycle as lat_rst.
- At most one lat_en bit is high at any time.
- lat_en never rises in the same cycle lat_data changes.
- req[w] dropping after SETUP: the transaction still completes and gnt[w] still pulses.
- req_data changing after SETUP is ignored.
- clr_req asserting during SETUP or OPEN is deferred to the HOLD decision. The in-flight write completes first.
- Simultaneous clr_req and req in IDLE or HOLD: CLEAR wins, and the writes are served afterwards.
- reset mid-operation: on the next edge lat_en=0, lat_rst=1, state=IDLE, no gnt is emitted, and ptr=0.
- OPEN_CYC=0: the counter loads 1.

Test Plan:
All scenarios use NUM_REQ=3, DW=8, OPEN_CYC=2.
- Single write: req=3'b010, req_data[15:8]=8'hA5.
  - SETUP is the next cycle and lat_data=8'hA5 from the following cycle.
  - lat_en=3'b010 for 2 cycles, then gnt=3'b010 for 1 cycle in HOLD.
  - The gnt edge is 4 cycles after req is sampled; busy is high for 4 cycles.
- Round-robin: req=3'b111 held, with each bit dropped on its gnt.
  - Grant order is 0, 1, 2 with no IDLE cycle between transactions, and gnt pulses are 4 cycles apart.
  - Repeat with req=3'b101 after ptr=1: order is 2 then 0.
- Clear priority: clr_req=1 and req=3'b001 together in IDLE.
  - lat_rst=1 for 1 cycle with lat_en=0 throughout, then the write to latch 0 proceeds.
  - Assert clr_req during OPEN instead: lat_rst rises only after HOLD, and gnt=3'b001 is still issued.
- Request withdrawn: req[2] drops and req_data changes to 8'h00 during OPEN.
  - lat_data holds its captured value 8'h3C, lat_en[2] is high for the full 2 cycles, and gnt[2] pulses.
- Reset mid-OPEN: reset=1 for 1 cycle during OPEN.
  - Next edge: lat_en=0, lat_rst=1, busy=0, no gnt.
  - After release, req=3'b011 grants index 0 first (ptr reset).
- Invariant checks, run throughout all scenarios:
  - $onehot0(lat_en).
  - !(lat_rst && |lat_en).
  - lat_data stable whenever |lat_en or |lat_en is rising.
